// File: rtl/pc_gen.sv
// Program-counter generator: start-up sequencing, valid/ready fetch handshake, EX redirects, hazard halt codes.
// Define PC_BTB_EN to add a direct-mapped branch target buffer for next-PC prediction.
module pc_gen #(
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC  = '0,
  parameter int                 INST_BYTES = 4,
  parameter int                 BTB_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        halt_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic              fetch_ready_i,
  input  logic              bt_upd_i,
  input  logic [ADDR_W-1:0] bt_upd_pc_i,
  input  logic [ADDR_W-1:0] bt_upd_tgt_i,
  input  logic              bt_upd_taken_i,
  output logic              ce_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              pred_taken_o,
  output logic              misalign_o
);

  localparam int                S        = $clog2(INST_BYTES);
  localparam int                I        = $clog2(BTB_DEPTH);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INST_BYTES);

  localparam logic [1:0] HALT_RUN    = 2'b00;
  localparam logic [1:0] HALT_STALL  = 2'b01;
  localparam logic [1:0] HALT_BUBBLE = 2'b10;
  localparam logic [1:0] HALT_HALT   = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;

  state_e            state_q, state_d;
  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic              misalign_q, misalign_d;

  logic              btb_hit_taken;
  logic [ADDR_W-1:0] btb_tgt;
  logic [ADDR_W-1:0] next_pc;
  logic              accept;

`ifdef PC_BTB_EN
  localparam int TAG_W = ADDR_W - S - I;

  logic              btb_valid_q [BTB_DEPTH];
  logic              btb_valid_d [BTB_DEPTH];
  logic [TAG_W-1:0]  btb_tag_q   [BTB_DEPTH];
  logic [TAG_W-1:0]  btb_tag_d   [BTB_DEPTH];
  logic [ADDR_W-1:0] btb_tgt_q   [BTB_DEPTH];
  logic [ADDR_W-1:0] btb_tgt_d   [BTB_DEPTH];

  logic [I-1:0]      rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;

  assign rd_idx = I'(pc_q >> S);
  assign rd_tag = TAG_W'(pc_q >> (S + I));
  assign wr_idx = I'(bt_upd_pc_i >> S);
  assign wr_tag = TAG_W'(bt_upd_pc_i >> (S + I));

  // Lookup reads the registered entries, so a same-cycle write is seen only next cycle.
  assign btb_hit_taken = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
  assign btb_tgt       = btb_tgt_q[rd_idx];

  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    if (bt_upd_i) begin
      if (bt_upd_taken_i) begin
        btb_valid_d[wr_idx] = 1'b1;
        btb_tag_d[wr_idx]   = wr_tag;
        btb_tgt_d[wr_idx]   = bt_upd_tgt_i & ~LOW_MASK;
      end else if (btb_tag_q[wr_idx] == wr_tag) begin
        btb_valid_d[wr_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_q <= '{default: 1'b0};
    end else begin
      btb_valid_q <= btb_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    btb_tag_q <= btb_tag_d;
    btb_tgt_q <= btb_tgt_d;
  end
`else
  logic unused_btb;

  assign btb_hit_taken = 1'b0;
  assign btb_tgt       = '0;
  assign unused_btb    = ^{bt_upd_i, bt_upd_pc_i, bt_upd_tgt_i, bt_upd_taken_i};
`endif

  assign next_pc = btb_hit_taken ? btb_tgt : pc_q + INC;
  assign accept  = pc_valid_q && fetch_ready_i && (halt_i == HALT_RUN);

  // Redirect beats every hold condition; stall/not-ready is checked before bubble and halt.
  always_comb begin
    state_d      = state_q;
    ce_d         = ce_q;
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    pred_taken_d = pred_taken_q;
    misalign_d   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d    = RUN;
        ce_d       = 1'b1;
        pc_valid_d = 1'b1;
      end
      RUN, HALTED: begin
        if (redirect_i) begin
          state_d      = RUN;
          pc_d         = redirect_addr_i & ~LOW_MASK;
          pc_valid_d   = 1'b1;
          pred_taken_d = 1'b0;
          misalign_d   = |(redirect_addr_i & LOW_MASK);
        end else if (state_q == HALTED) begin
          state_d = HALTED;
        end else if (halt_i == HALT_STALL || !fetch_ready_i) begin
          state_d = RUN;
        end else if (halt_i == HALT_BUBBLE) begin
          pc_valid_d = 1'b0;
        end else if (halt_i == HALT_HALT) begin
          state_d    = HALTED;
          pc_valid_d = 1'b0;
        end else if (accept) begin
          pc_d         = next_pc;
          pred_taken_d = btb_hit_taken;
        end else begin
          pc_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ce_q         <= 1'b0;
      pc_q         <= RESET_VEC;
      pc_valid_q   <= 1'b0;
      pred_taken_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ce_q         <= ce_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      pred_taken_q <= pred_taken_d;
      misalign_q   <= misalign_d;
    end
  end

  assign ce_o         = ce_q;
  assign pc_o         = pc_q;
  assign pc_valid_o   = pc_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign misalign_o   = misalign_q;

endmodule
